// File: rtl/gray_counter.sv
// Up/down binary counter that registers its Gray encoding alongside the count,
// with optional saturation and a one-cycle terminal pulse at the limits.
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          tc_d  = 1'b1;
          bin_d = (SATURATE != 0) ? MAX_VAL : MIN_VAL;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == MIN_VAL) begin
          tc_d  = 1'b1;
          bin_d = (SATURATE != 0) ? MIN_VAL : MAX_VAL;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
    // Encode the next count so gray and bin always describe the same value.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized and directed check of gray_counter (wrapping and saturating builds)
// against an integer reference model and a Gray-to-binary converter model.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_bin;
  logic [3:0] gray0, bin0, gray1, bin1;
  logic       tc0, tc1;

  int n_chk  = 0;
  int n_fail = 0;

  int m0, m1;
  bit mtc0, mtc1;
  logic [3:0] pg0, pb0, pg1, pb1;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(gray0), .bin(bin0), .tc(tc0)
  );

  gray_counter #(.WIDTH(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(gray1), .bin(bin1), .tc(tc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream converter: each binary bit is the XOR of all Gray bits above and at it.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model(inout int m, inout bit t, input bit sat,
                       input logic r, e, u, l, input logic [3:0] lb);
    if (r) begin
      m = 0; t = 0;
    end else if (l) begin
      m = lb; t = 0;
    end else if (e) begin
      t = 0;
      if (u) begin
        if (m == 15) begin t = 1; m = sat ? 15 : 0; end
        else m = m + 1;
      end else begin
        if (m == 0) begin t = 1; m = sat ? 0 : 15; end
        else m = m - 1;
      end
    end else begin
      t = 0;
    end
  endtask

  task automatic check_dut(input string n, input logic [3:0] g, b, input logic t,
                           input int m, input bit mt, input logic [3:0] pg, pb,
                           input bit jump);
    logic [3:0] mb;
    mb = m[3:0];
    chk({n, "_bin"}, b, mb);
    chk({n, "_gray"}, g, mb ^ (mb >> 1));
    chk({n, "_tc"}, t, mt);
    chk({n, "_conv"}, g2b(g), b);
    if (!jump && b !== pb) chk({n, "_onebit"}, $countones(g ^ pg), 1);
  endtask

  task automatic step(input logic r, e, u, l, input logic [3:0] lb);
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_bin = lb;
    pg0 = gray0; pb0 = bin0; pg1 = gray1; pb1 = bin1;
    @(posedge clk);
    model(m0, mtc0, 1'b0, r, e, u, l, lb);
    model(m1, mtc1, 1'b1, r, e, u, l, lb);
    #1;
    check_dut("w", gray0, bin0, tc0, m0, mtc0, pg0, pb0, r || l);
    check_dut("s", gray1, bin1, tc1, m1, mtc1, pg1, pb1, r || l);
  endtask

  logic [3:0] up_seq [16];

  initial begin
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;
    m0 = 0; m1 = 0; mtc0 = 0; mtc1 = 0;

    // Reset wins over load and enable
    step(1, 1, 1, 1, 4'd5);
    step(1, 1, 1, 1, 4'd5);
    chk("rst_gray", gray0, 4'd0);
    chk("rst_bin", bin0, 4'd0);
    chk("rst_tc", tc0, 1'b0);
    step(0, 1, 1, 0, 4'd0);
    chk("rst_resume", bin0, 4'd1);

    // Full up sequence from 0 through the wrap
    step(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, 0, 4'd0);
      chk("up_seq", gray0, up_seq[i]);
      chk("up_tc", tc0, (i == 15));
      chk("up_enc", gray0, bin0 ^ (bin0 >> 1));
    end

    // Down wrap from 0
    step(0, 1, 0, 0, 4'd0);
    chk("dn_gray", gray0, 4'h8);
    chk("dn_tc", tc0, 1'b1);
    step(0, 1, 0, 0, 4'd0);
    chk("dn_gray2", gray0, 4'h9);
    chk("dn_bin2", bin0, 4'd14);
    chk("dn_tc2", tc0, 1'b0);

    // Load beats enable
    step(0, 1, 0, 1, 4'd5);
    chk("ld_bin", bin0, 4'd5);
    chk("ld_gray", gray0, 4'd7);
    chk("ld_tc", tc0, 1'b0);
    step(0, 1, 1, 0, 4'd0);
    chk("ld_next_bin", bin0, 4'd6);
    chk("ld_next_gray", gray0, 4'd5);

    // Saturation at the top limit
    step(0, 0, 1, 1, 4'd15);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 4'd0);
      chk("sat_bin", bin1, 4'd15);
      chk("sat_gray", gray1, 4'h8);
      chk("sat_tc", tc1, 1'b1);
    end
    step(0, 1, 0, 0, 4'd0);
    chk("sat_dn_bin", bin1, 4'd14);
    chk("sat_dn_tc", tc1, 1'b0);

    // Saturation at the bottom limit
    step(0, 0, 1, 1, 4'd0);
    step(0, 1, 0, 0, 4'd0);
    chk("sat0_bin", bin1, 4'd0);
    chk("sat0_tc", tc1, 1'b1);

    // Random en/up traffic with occasional load and reset
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(49) == 0), ($urandom_range(3) != 0), $urandom_range(1),
           ($urandom_range(9) == 0), 4'($urandom_range(15)));
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, ($urandom_range(3) != 0), $urandom_range(1), 1'b0, 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
